mac_row_seq: RTL and testbench

MAC_ROW_SEQ -- requirements
Module: mac_row_seq

---
 rtl/mac_row_seq_pkg.sv | 15 +
 rtl/mac_row_seq_if.sv | 36 +++
 rtl/mac_row_seq_mul_add.sv | 24 ++
 rtl/mac_row_seq.sv | 153 +++++++++++++++
 tb/tb_mac_row_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mac_row_seq_pkg.sv
// Shared definitions for the MAC row sequencer: default geometry and the
// FSM state encoding used by the top level.
package mac_row_seq_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_NUM_WORDS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/mac_row_seq_if.sv
// Handshake bundle of the MAC row sequencer: row start, operand pair
// stream in, result word stream out, and status.
interface mac_row_seq_if
    import mac_row_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WORDS  = DEF_NUM_WORDS
) ();

    localparam int IDX_W = $clog2(NUM_WORDS + 1);

    logic                  start;
    logic [DATA_WIDTH-1:0] b_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a_word;
    logic [DATA_WIDTH-1:0] t_word;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_word;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, b_in, in_valid, a_word, t_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last, busy, done
    );

    modport slave (
        input  start, b_in, in_valid, a_word, t_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last, busy, done
    );

endinterface

// File: rtl/mac_row_seq_mul_add.sv
// One word step of the row: {c_next, s} = x*y + z + last_c.
// The worst case (2^W-1)^2 + 2*(2^W-1) equals 2^(2W)-1, so a 2W-bit
// result never overflows.
module mul_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    input  logic [W-1:0] last_c,
    output logic [W-1:0] s,
    output logic [W-1:0] c_next
);

    logic [2*W-1:0] full_s;

    assign full_s = ({{W{1'b0}}, x} * {{W{1'b0}}, y})
                  + {{W{1'b0}}, z}
                  + {{W{1'b0}}, last_c};

    assign s      = full_s[W-1:0];
    assign c_next = full_s[2*W-1:W];

endmodule

// File: rtl/mac_row_seq.sv
// MAC row sequencer: streams T' = T + A*b one word per accepted pair,
// LSW first, then emits the final carry word flagged with out_last.
// Optional build macro MAC_ROW_SEQ_ABORT_EN adds an abort input that
// returns the row to IDLE from any state without a done pulse.
module mac_row_seq
    import mac_row_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
    input  logic clk,
    input  logic rst,
`ifdef MAC_ROW_SEQ_ABORT_EN
    input  logic abort,
`endif
    mac_row_seq_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] CARRY_IDX = IDX_W'(NUM_WORDS);

    state_t                state_r;
    state_t                state_nx_s;
    logic [DATA_WIDTH-1:0] b_r;
    logic [DATA_WIDTH-1:0] carry_r;
    logic [IDX_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] out_word_r;
    logic [IDX_W-1:0]      out_idx_r;
    logic                  out_valid_r;
    logic                  out_last_r;
    logic [DATA_WIDTH-1:0] sum_s;
    logic [DATA_WIDTH-1:0] carry_nx_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  start_ok_s;
    logic                  load_carry_s;
    logic                  out_hs_s;
    logic                  carry_hs_s;
    logic                  abort_s;

`ifdef MAC_ROW_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    mul_add #(.W(DATA_WIDTH)) u_mul_add (
        .x      (bus.a_word),
        .y      (b_r),
        .z      (bus.t_word),
        .last_c (carry_r),
        .s      (sum_s),
        .c_next (carry_nx_s)
    );

    assign in_ready_s   = (state_r == ST_RUN) && (!out_valid_r || bus.out_ready);
    assign accept_s     = bus.in_valid && in_ready_s;
    assign start_ok_s   = (state_r == ST_IDLE) && bus.start;
    assign out_hs_s     = out_valid_r && bus.out_ready;
    // The carry word may only replace the last data word once that word is gone.
    assign load_carry_s = (state_r == ST_FLUSH) && !out_last_r
                        && (!out_valid_r || bus.out_ready);
    assign carry_hs_s   = (state_r == ST_FLUSH) && out_last_r && out_hs_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort wins over everything, including start.
    always_comb begin
        state_nx_s = state_r;
        if (abort_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) state_nx_s = ST_RUN;
                    else           state_nx_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (accept_s && (cnt_r == LAST_PAIR)) state_nx_s = ST_FLUSH;
                    else                                  state_nx_s = ST_RUN;
                end
                ST_FLUSH: begin
                    if (carry_hs_s) state_nx_s = ST_DONE;
                    else            state_nx_s = ST_FLUSH;
                end
                ST_DONE:  state_nx_s = ST_IDLE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Row datapath: multiplier latch, carry chain, word counter, result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_r         <= {DATA_WIDTH{1'b0}};
            carry_r     <= {DATA_WIDTH{1'b0}};
            cnt_r       <= {IDX_W{1'b0}};
            out_word_r  <= {DATA_WIDTH{1'b0}};
            out_idx_r   <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (abort_s) begin
            carry_r     <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            if (start_ok_s) begin
                b_r     <= bus.b_in;
                carry_r <= {DATA_WIDTH{1'b0}};
                cnt_r   <= {IDX_W{1'b0}};
            end else if (accept_s) begin
                carry_r <= carry_nx_s;
                cnt_r   <= cnt_r + IDX_W'(1);
            end else begin
                carry_r <= carry_r;
            end

            if (accept_s) begin
                out_word_r  <= sum_s;
                out_idx_r   <= cnt_r;
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b0;
            end else if (load_carry_s) begin
                out_word_r  <= carry_r;
                out_idx_r   <= CARRY_IDX;
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b1;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_word  = out_word_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_mac_row_seq.sv
// Bench for mac_row_seq (DATA_WIDTH=8, NUM_WORDS=4). Expected words come
// from evaluating T + A*b as one wide integer and slicing it into words.
module tb_mac_row_seq;

    localparam int DW = 8;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mac_row_seq_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

`ifdef MAC_ROW_SEQ_ABORT_EN
    logic abort;
`endif

    mac_row_seq #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef MAC_ROW_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: full rate, 1: out_ready low 3 cycles after first word,
    // 2: random valid/ready, 3: full rate with stray start pulses in RUN
    task automatic run_row(input string name, input logic [DW-1:0] b,
                           input logic [DW*NW-1:0] a_v, input logic [DW*NW-1:0] t_v,
                           input int mode);
        logic [63:0]   res;
        logic [DW-1:0] exp_w [NW+1];
        int sent, got, edges, stall_left;
        bit done_seen, ov, iv, ordy;
        res = 64'(t_v) + 64'(a_v) * 64'(b);
        for (int i = 0; i <= NW; i++) exp_w[i] = res[DW*i +: DW];
        sent = 0; got = 0; done_seen = 1'b0;
        stall_left = (mode == 1) ? 3 : 0;
        @(negedge clk);
        bus.start = 1'b1; bus.b_in = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.b_in = DW'($urandom);
        edges = 1;
        chk({name, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        while (!done_seen && edges < 60) begin
            ov = bus.out_valid;
            if (bus.done) begin
                done_seen = 1'b1;
                chk({name, "_words_before_done"}, 64'(got), 64'(NW + 1));
                if (mode == 0) chk({name, "_start_to_done"}, 64'(edges), 64'(NW + 3));
            end else begin
                if (mode == 1 && ov && stall_left > 0) begin
                    ordy = 1'b0; stall_left--;
                end else if (mode == 2) begin
                    ordy = 1'($urandom_range(0, 1));
                end else begin
                    ordy = 1'b1;
                end
                iv = (sent < NW) && ((mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1);
                bus.out_ready = ordy;
                bus.in_valid  = iv;
                bus.a_word = (sent < NW) ? a_v[DW*sent +: DW] : DW'($urandom);
                bus.t_word = (sent < NW) ? t_v[DW*sent +: DW] : DW'($urandom);
                if (mode == 3 && sent < NW) begin
                    bus.start = 1'($urandom_range(0, 1));
                    bus.b_in  = DW'($urandom);
                end else begin
                    bus.start = 1'b0;
                end
                #1;
                if (ov) begin
                    chk({name, "_word"}, 64'(bus.out_word), 64'(exp_w[got]));
                    chk({name, "_idx"},  64'(bus.out_idx),  64'(got));
                    chk({name, "_last"}, 64'(bus.out_last), 64'(got == NW));
                end
                if (ov && !ordy) chk({name, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
                if (mode == 0 && sent < NW) chk({name, "_full_rate_in_ready"}, 64'(bus.in_ready), 64'd1);
                if (iv && bus.in_ready) sent++;
                if (ov && ordy) got++;
                @(posedge clk); #1;
                edges++;
            end
        end
        bus.in_valid = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
        chk({name, "_done_seen"}, 64'(done_seen), 64'd1);
        @(posedge clk); #1;
        chk({name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
        chk({name, "_idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [DW*NW-1:0] ra;
        logic [DW*NW-1:0] rt;
        rst = 1'b1;
        bus.start = 1'b0; bus.b_in = '0; bus.in_valid = 1'b0;
        bus.a_word = '0; bus.t_word = '0; bus.out_ready = 1'b1;
`ifdef MAC_ROW_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({bus.out_valid, bus.out_last, bus.done, bus.busy,
                                  bus.in_ready, bus.out_idx, bus.out_word}), 64'd0);
        rst = 1'b0;

        run_row("all_ones", 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_row("carry_ripple", 8'h01, 32'h0000_0001, 32'h0000_FFFF, 0);
        ra = 32'($urandom);
        run_row("b_zero", 8'h00, ra, 32'h7856_3412, 0);
        run_row("stall3", 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        // abandon a row after two accepted pairs
        @(negedge clk);
        bus.start = 1'b1; bus.b_in = 8'h5A;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1; bus.a_word = DW'($urandom); bus.t_word = DW'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrow_reset_outputs", 64'({bus.out_valid, bus.out_last, bus.done, bus.busy,
                                        bus.in_ready, bus.out_idx, bus.out_word}), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("after_reset_quiet", 64'({bus.out_valid, bus.busy}), 64'd0);
        end
        run_row("fresh_row_start_noise", 8'h01, 32'h0000_0001, 32'h0000_FFFF, 3);

        for (int r = 0; r < 6; r++) begin
            ra = 32'($urandom);
            rt = 32'($urandom);
            run_row("random_row", DW'($urandom), ra, rt, 2);
        end

`ifdef MAC_ROW_SEQ_ABORT_EN
        @(negedge clk);
        bus.start = 1'b1; bus.b_in = 8'h33;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            bus.in_valid = 1'b1; bus.a_word = DW'($urandom); bus.t_word = DW'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("abort_pre_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bus.out_ready = 1'b1;
        chk("abort_idle", 64'(bus.busy), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_no_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        chk("abort_no_done_later", 64'(bus.done), 64'd0);
        run_row("after_abort", 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
